// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared types and helpers for the register-file write-port scheduler.
// Rev 1.0
`default_nettype none

package regfile_sched_pkg;

  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              double;
    logic [31:0]       data0;
    logic [31:0]       data1;
  } wb_entry_t;

  // Partner register of a pair; 31 wraps to 0.
  function automatic logic [REG_AW-1:0] pair(input logic [REG_AW-1:0] addr);
    return REG_AW'(addr + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO of long-unit writeback results (DEPTH a power of two).
// Rev 1.0
`default_nettype none

module wb_fifo
  import regfile_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_entry_t                    din,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            w_do_push;
  logic            w_do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      count    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between core writeback and
// buffered long-latency FP results, and stalls the core on FP RAW/WAW hazards. Rev 1.0
`default_nettype none

module regfile_wb_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_wen,
  input  logic              core_fp,
  input  logic              core_double,
  input  logic [REG_AW-1:0] core_waddr,
  input  logic [31:0]       core_wdata0,
  input  logic [31:0]       core_wdata1,
  input  logic [REG_AW-1:0] core_rs,
  input  logic [REG_AW-1:0] core_rt,
  input  logic              core_rs_fp,
  input  logic              core_rt_fp,
  input  logic              core_rd_double,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic              issue_double,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_dst,
  input  logic              lu_double,
  input  logic [31:0]       lu_data0,
  input  logic [31:0]       lu_data1,
  output logic              rf_wen,
  output logic              rf_fp,
  output logic              rf_fmt0,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata0,
  output logic [31:0]       rf_wdata1,
  output logic              stall,
  output logic [31:0]       busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_busy;
  wb_entry_t     w_head;
  wb_entry_t     w_lu_entry;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_core_take;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;

  function automatic logic hazard(input logic [31:0] sb, input logic [REG_AW-1:0] a,
                                  input logic dbl);
    return sb[a] | (dbl & sb[pair(a)]);
  endfunction

  function automatic logic [31:0] reg_mask(input logic [REG_AW-1:0] a, input logic dbl);
    logic [31:0] m;
    m = 32'd1 << a;
    if (dbl) m = m | (32'd1 << pair(a));
    return m;
  endfunction

  assign w_lu_entry = '{dst: lu_dst, double: lu_double, data0: lu_data0, data1: lu_data1};
  assign lu_ready   = rst_n && !w_full;
  assign w_push     = lu_valid && lu_ready;
  assign busy       = r_busy;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_lu_entry),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // A full FIFO with a pending core write stalls the core so the head can drain.
  always_comb begin
    stall = rst_n && (
              (core_rs_fp && hazard(r_busy, core_rs, core_rd_double)) ||
              (core_rt_fp && hazard(r_busy, core_rt, core_rd_double)) ||
              (core_wen && core_fp && hazard(r_busy, core_waddr, core_double)) ||
              (issue_valid && hazard(r_busy, issue_dst, issue_double)) ||
              (core_wen && (w_count == CW'(DEPTH))));
    w_core_take = rst_n && core_wen && !stall;
    w_pop       = rst_n && !w_core_take && !w_empty;
  end

  always_comb begin
    rf_wen    = 1'b0;
    rf_fp     = 1'b0;
    rf_fmt0   = 1'b0;
    rf_waddr  = '0;
    rf_wdata0 = '0;
    rf_wdata1 = '0;
    if (w_core_take) begin
      rf_wen    = 1'b1;
      rf_fp     = core_fp;
      rf_fmt0   = core_double;
      rf_waddr  = core_waddr;
      rf_wdata0 = core_wdata0;
      rf_wdata1 = core_wdata1;
    end else if (w_pop) begin
      rf_wen    = 1'b1;
      rf_fp     = 1'b1;
      rf_fmt0   = w_head.double;
      rf_waddr  = w_head.dst;
      rf_wdata0 = w_head.data0;
      rf_wdata1 = w_head.data1;
    end
  end

  // Set is applied after clear so a same-cycle issue keeps the bit busy.
  assign w_set = (issue_valid && !stall) ? reg_mask(issue_dst, issue_double) : '0;
  assign w_clr = w_pop ? reg_mask(w_head.dst, w_head.double) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_clr) | w_set;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed stimulus; expected register-file writes are queued
// at issue time and a negedge monitor pops and compares each write the DUT performs.
`default_nettype none

module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_wen, core_fp, core_double;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata0, core_wdata1;
  logic [4:0]  core_rs, core_rt;
  logic        core_rs_fp, core_rt_fp, core_rd_double;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        issue_double;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_dst;
  logic        lu_double;
  logic [31:0] lu_data0, lu_data1;
  logic        rf_wen, rf_fp, rf_fmt0;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata0, rf_wdata1;
  logic        stall;
  logic [31:0] busy;

  int          checks = 0;
  int          errors = 0;
  logic [70:0] exp_q[$];
  logic [70:0] mon_exp;
  logic [70:0] mon_act;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_wen(core_wen), .core_fp(core_fp), .core_double(core_double),
    .core_waddr(core_waddr), .core_wdata0(core_wdata0), .core_wdata1(core_wdata1),
    .core_rs(core_rs), .core_rt(core_rt), .core_rs_fp(core_rs_fp), .core_rt_fp(core_rt_fp),
    .core_rd_double(core_rd_double),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_double(issue_double),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dst(lu_dst), .lu_double(lu_double),
    .lu_data0(lu_data0), .lu_data1(lu_data1),
    .rf_wen(rf_wen), .rf_fp(rf_fp), .rf_fmt0(rf_fmt0), .rf_waddr(rf_waddr),
    .rf_wdata0(rf_wdata0), .rf_wdata1(rf_wdata1),
    .stall(stall), .busy(busy)
  );

  function automatic logic [70:0] wr(input logic fp, input logic fmt, input logic [4:0] a,
                                     input logic [31:0] d0, input logic [31:0] d1);
    return {fp, fmt, a, d0, d1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic idle();
    core_wen = 0; core_fp = 0; core_double = 0; core_waddr = 0;
    core_wdata0 = 0; core_wdata1 = 0;
    core_rs = 0; core_rt = 0; core_rs_fp = 0; core_rt_fp = 0; core_rd_double = 0;
    issue_valid = 0; issue_dst = 0; issue_double = 0;
    lu_valid = 0; lu_dst = 0; lu_double = 0; lu_data0 = 0; lu_data1 = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic core_int(input logic [31:0] d);
    core_wen = 1; core_fp = 0; core_double = 0; core_waddr = 5'd5;
    core_wdata0 = d; core_wdata1 = 0;
  endtask

  task automatic lu_push(input logic [4:0] d, input logic dbl, input logic [31:0] d0,
                         input logic [31:0] d1);
    lu_valid = 1; lu_dst = d; lu_double = dbl; lu_data0 = d0; lu_data1 = d1;
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_wen !== 1'b0) begin
      checks++;
      mon_act = {rf_fp, rf_fmt0, rf_waddr, rf_wdata0, rf_wdata1};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h expected no write", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL rf_write: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    core_int(32'hDEAD0000);
    @(negedge clk);
    chk("rst_rf_wen", 32'(rf_wen), 0);
    chk("rst_lu_ready", 32'(lu_ready), 0);
    chk("rst_stall", 32'(stall), 0);
    cyc(); idle();
    cyc(); rst_n = 1;
    @(negedge clk);
    chk("post_rst_lu_ready", 32'(lu_ready), 1);
    chk("post_rst_busy", busy, 0);

    // Single-precision DIV to f4.
    cyc(); issue_valid = 1; issue_dst = 5'd4;
    @(negedge clk); chk("t1_issue_stall", 32'(stall), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle();
      @(negedge clk); chk("t1_busy_held", busy, 32'h0000_0010);
    end
    cyc(); lu_push(5'd4, 0, 32'h4040_0000, 0);
    exp_q.push_back(wr(1, 0, 5'd4, 32'h4040_0000, 0));
    @(negedge clk); chk("t1_lu_ready", 32'(lu_ready), 1);
    cyc(); idle();
    @(negedge clk); chk("t1_busy_wb_cycle", busy, 32'h0000_0010);
    cyc();
    @(negedge clk); chk("t1_busy_clear", busy, 0);

    // Double to f30/f31 with a RAW read of f31.
    cyc(); issue_valid = 1; issue_dst = 5'd30; issue_double = 1;
    @(negedge clk); chk("t2_issue_stall", 32'(stall), 0);
    cyc(); idle(); core_rs = 5'd31; core_rs_fp = 1;
    @(negedge clk); chk("t2_raw_stall", 32'(stall), 1); chk("t2_busy", busy, 32'hC000_0000);
    cyc(); lu_push(5'd30, 1, 32'h1111_1111, 32'h2222_2222);
    exp_q.push_back(wr(1, 1, 5'd30, 32'h1111_1111, 32'h2222_2222));
    @(negedge clk); chk("t2_stall_push", 32'(stall), 1);
    cyc(); lu_valid = 0;
    @(negedge clk); chk("t2_stall_wb", 32'(stall), 1);
    cyc();
    @(negedge clk); chk("t2_release", 32'(stall), 0); chk("t2_busy_clear", busy, 0);

    // Double to f31 wraps to f0; WAW and issue hazards through the partner.
    cyc(); idle(); issue_valid = 1; issue_dst = 5'd31; issue_double = 1;
    @(negedge clk); chk("t3_issue_stall", 32'(stall), 0);
    cyc(); idle(); core_wen = 1; core_fp = 1; core_double = 1; core_waddr = 5'd30;
    @(negedge clk); chk("t3_waw_stall", 32'(stall), 1); chk("t3_busy", busy, 32'h8000_0001);
    cyc(); idle(); issue_valid = 1; issue_dst = 5'd0;
    lu_push(5'd31, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    exp_q.push_back(wr(1, 1, 5'd31, 32'hA5A5_A5A5, 32'h5A5A_5A5A));
    @(negedge clk); chk("t3_issue_hazard", 32'(stall), 1);
    cyc(); idle();
    @(negedge clk); chk("t3_busy_wb_cycle", busy, 32'h8000_0001);
    cyc();
    @(negedge clk); chk("t3_busy_clear", busy, 0);

    // Integer writes every cycle while two results fill the FIFO.
    cyc(); core_int(32'h0000_00D1); lu_push(5'd8, 0, 32'h88, 0);
    exp_q.push_back(wr(0, 0, 5'd5, 32'h0000_00D1, 0));
    @(negedge clk); chk("t4_c1_stall", 32'(stall), 0);
    cyc(); core_int(32'h0000_00D2); lu_push(5'd9, 0, 32'h99, 0);
    exp_q.push_back(wr(0, 0, 5'd5, 32'h0000_00D2, 0));
    @(negedge clk); chk("t4_c2_lu_ready", 32'(lu_ready), 1);
    cyc(); core_int(32'h0000_00D3); lu_valid = 0;
    exp_q.push_back(wr(1, 0, 5'd8, 32'h88, 0));
    @(negedge clk); chk("t4_full_lu_ready", 32'(lu_ready), 0);
    chk("t4_full_stall", 32'(stall), 1);
    cyc();
    exp_q.push_back(wr(0, 0, 5'd5, 32'h0000_00D3, 0));
    @(negedge clk); chk("t4_core_resume", 32'(stall), 0);
    cyc(); idle();
    exp_q.push_back(wr(1, 0, 5'd9, 32'h99, 0));
    @(negedge clk); chk("t4_drain_lu_ready", 32'(lu_ready), 1);

    // Pop of f2 and issue to f2 in the same cycle: the set wins.
    cyc(); lu_push(5'd2, 0, 32'h22, 0);
    @(negedge clk); chk("t5_busy_pre", busy, 0);
    cyc(); idle(); issue_valid = 1; issue_dst = 5'd2;
    exp_q.push_back(wr(1, 0, 5'd2, 32'h22, 0));
    @(negedge clk); chk("t5_issue_stall", 32'(stall), 0);
    cyc(); idle();
    @(negedge clk); chk("t5_set_wins", busy, 32'h0000_0004);
    cyc(); lu_push(5'd2, 0, 32'h33, 0);
    exp_q.push_back(wr(1, 0, 5'd2, 32'h33, 0));
    cyc(); idle();
    cyc();
    @(negedge clk); chk("t5_busy_clear", busy, 0);

    // Reset with two results buffered and a busy bit set.
    cyc(); core_int(32'h0000_00E1); lu_push(5'd10, 0, 32'hA0, 0);
    issue_valid = 1; issue_dst = 5'd12;
    exp_q.push_back(wr(0, 0, 5'd5, 32'h0000_00E1, 0));
    cyc(); core_int(32'h0000_00E2); lu_push(5'd11, 0, 32'hB0, 0); issue_valid = 0;
    exp_q.push_back(wr(0, 0, 5'd5, 32'h0000_00E2, 0));
    @(negedge clk); chk("t6_busy_set", busy, 32'h0000_1000);
    cyc(); idle(); rst_n = 0;
    @(negedge clk); chk("t6_rst_rf_wen", 32'(rf_wen), 0);
    chk("t6_rst_lu_ready", 32'(lu_ready), 0);
    cyc();
    cyc(); rst_n = 1;
    @(negedge clk); chk("t6_busy_after", busy, 0); chk("t6_lu_ready_after", 32'(lu_ready), 1);
    chk("t6_no_stale", 32'(rf_wen), 0);
    cyc(); cyc();
    @(negedge clk); chk("t6_queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
